hazard_stall_unit: RTL

Pipeline hazard and stall controller for the five-stage LC-3b pipeline. It covers the hazards that operand bypassing cannot resolve: load-use dependences, instruction-cache and data-cache misses, and control redirects resolved in MEM. It drives per-stage load, flush and bubble controls to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating stall and bubble performance counters.

---
 rtl/hazard_stall_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// LC-3b hazard/stall controller: per-stage load/flush/bubble enables, combinational (zero latency).
// Stalls freeze upstream stages while later stages drain; perf counters update on the next edge.
module hazard_stall_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  id_sr1,
  input  logic [2:0]  id_sr2,
  input  logic        id_uses_sr1,
  input  logic        id_uses_sr2,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [2:0]  ex_dest,
  input  logic        icache_resp,
  input  logic        mem_access,
  input  logic        dcache_resp,
  input  logic        mem_redirect,
  input  logic        perf_clear,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        insert_bubble,
  output logic [15:0] stall_count,
  output logic [15:0] bubble_count
);

  typedef enum logic [1:0] {RUN, DMISS, REDIR} state_t;

  state_t state, state_nxt;
  logic   mem_busy;
  logic   load_use;

  assign mem_busy = mem_access & ~dcache_resp;
  assign load_use = ex_mem_read & ex_reg_write &
                    ((id_uses_sr1 & (id_sr1 == ex_dest)) |
                     (id_uses_sr2 & (id_sr2 == ex_dest)));

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    load_pc       = 1'b0;
    load_if_id    = 1'b0;
    load_id_ex    = 1'b0;
    load_ex_mem   = 1'b0;
    load_mem_wb   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    insert_bubble = 1'b0;
    state_nxt     = RUN;
    if (reset) begin
      // Every pipeline register loads NOP; the PC resets itself.
      load_if_id    = 1'b1;
      load_id_ex    = 1'b1;
      load_ex_mem   = 1'b1;
      load_mem_wb   = 1'b1;
      flush_if_id   = 1'b1;
      flush_id_ex   = 1'b1;
      flush_ex_mem  = 1'b1;
      insert_bubble = 1'b1;
    end else if (state == REDIR) begin
      // ID is about to be squashed, so a load-use match here is irrelevant.
      if (icache_resp) begin
        {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
        {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b111;
      end else begin
        state_nxt = REDIR;
      end
    end else if (mem_busy) begin
      state_nxt = DMISS;
    end else if (mem_redirect && !icache_resp) begin
      // Hold the in-flight fetch address until the icache answers.
      state_nxt = REDIR;
    end else if (mem_redirect) begin
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
      {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b111;
    end else if (load_use) begin
      {load_id_ex, load_ex_mem, load_mem_wb} = 3'b111;
      insert_bubble = 1'b1;
    end else if (!icache_resp) begin
      {load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 4'b1111;
      flush_if_id = 1'b1;
    end else begin
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      stall_count  <= 16'h0000;
      bubble_count <= 16'h0000;
    end else begin
      if (!load_pc && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (insert_bubble && bubble_count != 16'hFFFF)
        bubble_count <= bubble_count + 16'd1;
    end
  end

endmodule
